// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder in front of a word-organised SRAM array: pipelined address/data
// phases, programmable wait states, byte/half/word lane enables, two-cycle ERROR replies.
module ahb_sram_slave #(
   parameter int ADDR_WIDTH  = 12,
   parameter int WAIT_STATES = 0
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic [2:0]  HSIZE,
   input  logic        HWRITE,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA
);

   localparam int IW    = ADDR_WIDTH - 2;
   localparam int DEPTH = 2 ** IW;
   localparam logic [2:0] WS_LAST = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_DATA,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t          state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [3:0]      be_q, be_d;
   logic            write_q, write_d;
   logic            hreadyout_q, hreadyout_d;
   logic            hresp_q, hresp_d;
   logic [31:0]     mem_q [DEPTH];

   logic            accept;
   logic            illegal;
   logic            rd_active;
   logic [3:0]      lane_be;

   // Only the bits above the decoded window and HTRANS[0] are deliberately ignored.
   logic unused_ok;
   assign unused_ok = ^{HADDR[31:ADDR_WIDTH], HTRANS[0]};

   assign accept  = HSEL & HREADY & HTRANS[1];
   assign illegal = (HSIZE > 3'd2)
                  | ((HSIZE == 3'd1) & HADDR[0])
                  | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));

   always_comb begin
      lane_be = 4'b1111;
      case (HSIZE)
         3'd0:    lane_be = 4'b0001 << HADDR[1:0];
         3'd1:    lane_be = HADDR[1] ? 4'b1100 : 4'b0011;
         default: lane_be = 4'b1111;
      endcase
   end

   always_comb begin
      logic take_new;
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      be_d     = be_q;
      write_d  = write_q;
      take_new = 1'b0;

      case (state_q)
         S_IDLE, S_DATA, S_ERR2: begin
            state_d  = S_IDLE;
            take_new = 1'b1;
         end
         S_WAIT: begin
            if (cnt_q == WS_LAST) state_d = S_DATA;
            else                  cnt_d   = cnt_q + 3'd1;
         end
         S_ERR1:  state_d = S_ERR2;
         default: state_d = S_IDLE;
      endcase

      // Address phase is only taken while this slave is not stalling the bus.
      if (take_new && accept) begin
         idx_d   = HADDR[ADDR_WIDTH-1:2];
         be_d    = lane_be;
         write_d = HWRITE & ~illegal;
         cnt_d   = 3'd0;
         if (illegal)              state_d = S_ERR1;
         else if (WAIT_STATES > 0) state_d = S_WAIT;
         else                      state_d = S_DATA;
      end

      hreadyout_d = !(state_d inside {S_WAIT, S_ERR1});
      hresp_d     =  (state_d inside {S_ERR1, S_ERR2});
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q     <= S_IDLE;
         cnt_q       <= 3'd0;
         idx_q       <= '0;
         be_q        <= 4'd0;
         write_q     <= 1'b0;
         hreadyout_q <= 1'b1;
         hresp_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         be_q        <= be_d;
         write_q     <= write_d;
         hreadyout_q <= hreadyout_d;
         hresp_q     <= hresp_d;
      end
   end

   // Write commits on the edge closing the data phase, so a read pipelined right
   // behind it already sees the new word.
   always_ff @(posedge HCLK) begin
      if (!HRESET && (state_q == S_DATA) && write_q) begin
         for (int b = 0; b < 4; b++) begin
            if (be_q[b]) mem_q[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
         end
      end
   end

   assign rd_active = (state_q inside {S_WAIT, S_DATA}) && !write_q;

   assign HREADYOUT = hreadyout_q;
   assign HRESP     = hresp_q;
   assign HRDATA    = rd_active ? mem_q[idx_q] : 32'd0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: a zero-wait and a three-wait instance share the bus wires; each row
// selects one of them and lists the response expected in that cycle.
module tb_ahb_sram_slave;

   localparam logic [1:0] IDL = 2'b00, BSY = 2'b01, NSQ = 2'b10, SEQ = 2'b11;
   localparam logic [2:0] SB = 3'd0, SH = 3'd1, SW = 3'd2, S3 = 3'd3;

   logic        clk = 1'b0;
   logic        rst;
   logic        hsel0, hsel3;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic        hwrite;
   logic [31:0] hwdata;
   logic        ro0, rs0, ro3, rs3;
   logic [31:0] rd0, rd3;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ahb_sram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(0)) u_ws0 (
      .HCLK(clk), .HRESET(rst), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
      .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(ro0),
      .HREADYOUT(ro0), .HRESP(rs0), .HRDATA(rd0));

   ahb_sram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(3)) u_ws3 (
      .HCLK(clk), .HRESET(rst), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans),
      .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(ro3),
      .HREADYOUT(ro3), .HRESP(rs3), .HRDATA(rd3));

   typedef struct {
      logic        dut;
      logic        sel;
      logic [1:0]  trans;
      logic [2:0]  size;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        rdy;
      logic        resp;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic d, input logic s, input logic [1:0] tr,
                               input logic [2:0] sz, input logic wr, input logic [31:0] a,
                               input logic [31:0] wd, input logic rdy, input logic resp,
                               input logic [31:0] rdat);
      vec_t v;
      v.dut = d; v.sel = s; v.trans = tr; v.size = sz; v.wr = wr; v.addr = a;
      v.wdata = wd; v.rdy = rdy; v.resp = resp; v.rdata = rdat;
      vecs.push_back(v);
   endfunction

   task automatic drive(input logic d, input logic s, input logic [1:0] tr,
                        input logic [2:0] sz, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd);
      @(posedge clk);
      #1;
      hsel0  = s & ~d;
      hsel3  = s & d;
      htrans = tr;
      hsize  = sz;
      hwrite = wr;
      haddr  = a;
      hwdata = wd;
   endtask

   task automatic check(input string name, input logic d, input logic rdy,
                        input logic resp, input logic [31:0] rdat);
      logic        a_rdy, a_resp;
      logic [31:0] a_dat;
      @(negedge clk);
      a_rdy  = d ? ro3 : ro0;
      a_resp = d ? rs3 : rs0;
      a_dat  = d ? rd3 : rd0;
      n_tests++;
      if (a_rdy !== rdy || a_resp !== resp || a_dat !== rdat) begin
         n_fail++;
         $display("FAIL %s: got rdy=%0b resp=%0b rdata=%08h, expected rdy=%0b resp=%0b rdata=%08h",
                  name, a_rdy, a_resp, a_dat, rdy, resp, rdat);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int  waits;
      bit  got;

      rst = 1'b1; hsel0 = 1'b0; hsel3 = 1'b0; htrans = IDL; hsize = SW;
      hwrite = 1'b0; haddr = '0; hwdata = '0;

      // ---- zero-wait instance: pipelined word/byte/half, errors, ignored transfers, alias
      add(0,1,IDL,SW,0,32'h10,  32'h0,        1,0,32'h0);
      add(0,1,NSQ,SW,1,32'h10,  32'h0,        1,0,32'h0);
      add(0,1,NSQ,SW,0,32'h10,  32'hDEADBEEF, 1,0,32'h0);
      add(0,1,NSQ,SB,1,32'h13,  32'h0,        1,0,32'hDEADBEEF);
      add(0,1,NSQ,SH,1,32'h10,  32'hAA000000, 1,0,32'h0);
      add(0,1,NSQ,SW,0,32'h10,  32'h00005678, 1,0,32'h0);
      add(0,1,NSQ,SW,1,32'h20,  32'h0,        1,0,32'hAAAD5678);
      add(0,1,NSQ,SW,1,32'h11,  32'h11223344, 1,0,32'h0);
      add(0,1,IDL,SW,0,32'h0,   32'hFFFFFFFF, 0,1,32'h0);
      add(0,1,NSQ,S3,1,32'h20,  32'hFFFFFFFF, 1,1,32'h0);
      add(0,1,IDL,SW,0,32'h0,   32'hFFFFFFFF, 0,1,32'h0);
      add(0,1,NSQ,SH,1,32'h11,  32'hFFFFFFFF, 1,1,32'h0);
      add(0,1,IDL,SW,0,32'h0,   32'hFFFFFFFF, 0,1,32'h0);
      add(0,1,NSQ,SW,0,32'h20,  32'hFFFFFFFF, 1,1,32'h0);
      add(0,1,NSQ,SW,0,32'h10,  32'h0,        1,0,32'h11223344);
      add(0,0,NSQ,SW,1,32'h10,  32'h0,        1,0,32'hAAAD5678);
      add(0,1,IDL,SW,1,32'h10,  32'h0,        1,0,32'h0);
      add(0,1,BSY,SW,1,32'h10,  32'h0,        1,0,32'h0);
      add(0,1,NSQ,SW,0,32'h10,  32'h0,        1,0,32'h0);
      add(0,1,IDL,SW,0,32'h0,   32'h0,        1,0,32'hAAAD5678);
      add(0,1,NSQ,SW,1,32'h1010,32'h0,        1,0,32'h0);
      add(0,1,SEQ,SW,0,32'h0010,32'hCAFEF00D, 1,0,32'h0);
      add(0,1,IDL,SW,0,32'h0,   32'h0,        1,0,32'hCAFEF00D);

      // ---- three-wait instance: write/read/write/read back-to-back
      add(1,1,NSQ,SW,1,32'h10,32'h0,        1,0,32'h0);
      for (int k = 0; k < 3; k++) add(1,1,NSQ,SW,0,32'h10,32'h01020304, 0,0,32'h0);
      add(1,1,NSQ,SW,0,32'h10,32'h01020304, 1,0,32'h0);
      for (int k = 0; k < 3; k++) add(1,1,NSQ,SW,1,32'h10,32'h0, 0,0,32'h01020304);
      add(1,1,NSQ,SW,1,32'h10,32'h0,        1,0,32'h01020304);
      for (int k = 0; k < 3; k++) add(1,1,NSQ,SW,0,32'h10,32'h55667788, 0,0,32'h0);
      add(1,1,NSQ,SW,0,32'h10,32'h55667788, 1,0,32'h0);
      for (int k = 0; k < 3; k++) add(1,1,IDL,SW,0,32'h0,32'h0, 0,0,32'h55667788);
      add(1,1,IDL,SW,0,32'h0,32'h0,         1,0,32'h55667788);
      add(1,1,IDL,SW,0,32'h0,32'h0,         1,0,32'h0);

      @(posedge clk);
      #1;
      check("reset_ws0", 0, 1, 0, 32'h0);
      check("reset_ws3", 1, 1, 0, 32'h0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].dut, vecs[i].sel, vecs[i].trans, vecs[i].size, vecs[i].wr,
               vecs[i].addr, vecs[i].wdata);
         check($sformatf("vec%0d", i), vecs[i].dut, vecs[i].rdy, vecs[i].resp, vecs[i].rdata);
      end

      // ---- reset in the second wait cycle of a three-wait write
      drive(1,1,NSQ,SW,1,32'h10,32'h0);
      check("ws3_rst_addr", 1, 1, 0, 32'h0);
      drive(1,1,IDL,SW,0,32'h0,32'hDEADDEAD);
      check("ws3_rst_wait1", 1, 0, 0, 32'h0);
      drive(1,1,IDL,SW,0,32'h0,32'hDEADDEAD);
      rst = 1'b1;
      check("ws3_rst_wait2", 1, 0, 0, 32'h0);
      drive(1,1,NSQ,SW,0,32'h10,32'h0);
      rst = 1'b0;
      check("ws3_after_rst", 1, 1, 0, 32'h0);
      drive(1,1,IDL,SW,0,32'h0,32'h0);
      waits = 0;
      got   = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (ro3 === 1'b1) begin
            got = 1'b1;
            break;
         end
         waits++;
      end
      n_tests++;
      if (!got || waits != 3 || rd3 !== 32'h55667788 || rs3 !== 1'b0) begin
         n_fail++;
         $display("FAIL ws3_rd_after_rst: got ready=%0b waits=%0d rdata=%08h, expected ready=1 waits=3 rdata=55667788",
                  got, waits, rd3);
      end

      // ---- reset during the data phase of a zero-wait write drops the write
      drive(0,1,NSQ,SW,1,32'h10,32'h0);
      check("ws0_rst_addr", 0, 1, 0, 32'h0);
      drive(0,1,IDL,SW,0,32'h0,32'h12345678);
      rst = 1'b1;
      check("ws0_rst_data", 0, 1, 0, 32'h0);
      drive(0,1,NSQ,SW,0,32'h10,32'h0);
      rst = 1'b0;
      check("ws0_after_rst", 0, 1, 0, 32'h0);
      drive(0,1,IDL,SW,0,32'h0,32'h0);
      check("ws0_rd_old", 0, 1, 0, 32'hCAFEF00D);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
